// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with load-use detection and EX operand
//            forwarding from the EX/MEM and MEM/WB stages.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [63:0] id_pc,
    input  logic [63:0] id_rs1_data,
    input  logic [63:0] id_rs2_data,
    input  logic [63:0] id_imm,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  id_rd_addr,
    input  logic [3:0]  id_alu_control,
    input  logic        id_alu_src,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        id_mem_to_reg,
    input  logic        id_branch,
    input  logic [4:0]  exmem_rd,
    input  logic        exmem_reg_write,
    input  logic [63:0] exmem_alu_result,
    input  logic [4:0]  memwb_rd,
    input  logic        memwb_reg_write,
    input  logic [63:0] memwb_write_data,
    output logic        ex_valid,
    output logic [63:0] ex_pc,
    output logic [63:0] ex_imm,
    output logic [4:0]  ex_rd_addr,
    output logic [3:0]  ex_alu_control,
    output logic [63:0] ex_alu_a,
    output logic [63:0] ex_alu_b,
    output logic [63:0] ex_store_data,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic        ex_branch,
    output logic        load_use_hazard
);

    logic        valid_q,       valid_d;
    logic [63:0] pc_q,          pc_d;
    logic [63:0] rs1_data_q,    rs1_data_d;
    logic [63:0] rs2_data_q,    rs2_data_d;
    logic [63:0] imm_q,         imm_d;
    logic [4:0]  rs1_addr_q,    rs1_addr_d;
    logic [4:0]  rs2_addr_q,    rs2_addr_d;
    logic [4:0]  rd_addr_q,     rd_addr_d;
    logic [3:0]  alu_control_q, alu_control_d;
    logic        alu_src_q,     alu_src_d;
    logic        reg_write_q,   reg_write_d;
    logic        mem_read_q,    mem_read_d;
    logic        mem_write_q,   mem_write_d;
    logic        mem_to_reg_q,  mem_to_reg_d;
    logic        branch_q,      branch_d;

    logic [63:0] fwd_rs1;
    logic [63:0] fwd_rs2;

    // A load in EX whose destination is read by the instruction in ID.
    assign load_use_hazard = valid_q & mem_read_q & (rd_addr_q != 5'd0) & id_valid &
                             ((rd_addr_q == id_rs1_addr) | (rd_addr_q == id_rs2_addr));

    always_comb begin
        valid_d       = valid_q;
        pc_d          = pc_q;
        rs1_data_d    = rs1_data_q;
        rs2_data_d    = rs2_data_q;
        imm_d         = imm_q;
        rs1_addr_d    = rs1_addr_q;
        rs2_addr_d    = rs2_addr_q;
        rd_addr_d     = rd_addr_q;
        alu_control_d = alu_control_q;
        alu_src_d     = alu_src_q;
        reg_write_d   = reg_write_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_to_reg_d  = mem_to_reg_q;
        branch_d      = branch_q;
        if (flush || (!stall && load_use_hazard)) begin
            valid_d       = 1'b0;
            pc_d          = 64'd0;
            rs1_data_d    = 64'd0;
            rs2_data_d    = 64'd0;
            imm_d         = 64'd0;
            rs1_addr_d    = 5'd0;
            rs2_addr_d    = 5'd0;
            rd_addr_d     = 5'd0;
            alu_control_d = 4'd0;
            alu_src_d     = 1'b0;
            reg_write_d   = 1'b0;
            mem_read_d    = 1'b0;
            mem_write_d   = 1'b0;
            mem_to_reg_d  = 1'b0;
            branch_d      = 1'b0;
        end else if (!stall) begin
            valid_d       = id_valid;
            pc_d          = id_pc;
            rs1_data_d    = id_rs1_data;
            rs2_data_d    = id_rs2_data;
            imm_d         = id_imm;
            rs1_addr_d    = id_rs1_addr;
            rs2_addr_d    = id_rs2_addr;
            rd_addr_d     = id_rd_addr;
            alu_control_d = id_alu_control;
            alu_src_d     = id_alu_src;
            reg_write_d   = id_reg_write;
            mem_read_d    = id_mem_read;
            mem_write_d   = id_mem_write;
            mem_to_reg_d  = id_mem_to_reg;
            branch_d      = id_branch;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q       <= 1'b0;
            pc_q          <= 64'd0;
            rs1_data_q    <= 64'd0;
            rs2_data_q    <= 64'd0;
            imm_q         <= 64'd0;
            rs1_addr_q    <= 5'd0;
            rs2_addr_q    <= 5'd0;
            rd_addr_q     <= 5'd0;
            alu_control_q <= 4'd0;
            alu_src_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            branch_q      <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            pc_q          <= pc_d;
            rs1_data_q    <= rs1_data_d;
            rs2_data_q    <= rs2_data_d;
            imm_q         <= imm_d;
            rs1_addr_q    <= rs1_addr_d;
            rs2_addr_q    <= rs2_addr_d;
            rd_addr_q     <= rd_addr_d;
            alu_control_q <= alu_control_d;
            alu_src_q     <= alu_src_d;
            reg_write_q   <= reg_write_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_to_reg_q  <= mem_to_reg_d;
            branch_q      <= branch_d;
        end
    end

    // EX/MEM is the younger producer, so it is checked first; x0 is never forwarded.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs1_addr_q))
            fwd_rs1 = exmem_alu_result;
        else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs1_addr_q))
            fwd_rs1 = memwb_write_data;
    end

    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs2_addr_q))
            fwd_rs2 = exmem_alu_result;
        else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs2_addr_q))
            fwd_rs2 = memwb_write_data;
    end

    assign ex_valid       = valid_q;
    assign ex_pc          = pc_q;
    assign ex_imm         = imm_q;
    assign ex_rd_addr     = rd_addr_q;
    assign ex_alu_control = alu_control_q;
    assign ex_alu_a       = fwd_rs1;
    assign ex_alu_b       = alu_src_q ? imm_q : fwd_rs2;
    assign ex_store_data  = fwd_rs2;
    assign ex_reg_write   = reg_write_q & valid_q;
    assign ex_mem_read    = mem_read_q  & valid_q;
    assign ex_mem_write   = mem_write_q & valid_q;
    assign ex_mem_to_reg  = mem_to_reg_q;
    assign ex_branch      = branch_q    & valid_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// Testbench for id_ex_stage: scoreboard against a transaction-level model of
// the ID/EX register, plus directed scenarios with fixed expected values.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [3:0]  id_alu_control;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [63:0] exmem_alu_result, memwb_write_data;
    logic        ex_valid;
    logic [63:0] ex_pc, ex_imm, ex_alu_a, ex_alu_b, ex_store_data;
    logic [4:0]  ex_rd_addr;
    logic [3:0]  ex_alu_control;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
    logic        load_use_hazard;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_alu_control(id_alu_control), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_branch(id_branch), .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_alu_result(exmem_alu_result), .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
        .memwb_write_data(memwb_write_data), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rd_addr(ex_rd_addr), .ex_alu_control(ex_alu_control), .ex_alu_a(ex_alu_a),
        .ex_alu_b(ex_alu_b), .ex_store_data(ex_store_data), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch(ex_branch), .load_use_hazard(load_use_hazard)
    );

    typedef struct {
        bit reset, stall, flush, id_valid;
        logic [63:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        bit alu_src, rw, mr, mw, m2r, br;
        logic [4:0]  exmem_rd, memwb_rd;
        bit exmem_rw, memwb_rw;
        logic [63:0] exmem_res, memwb_data;
    } stim_t;

    // Contents of the EX slot as the model sees it.
    typedef struct {
        bit valid;
        logic [63:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        bit alu_src, rw, mr, mw, m2r, br;
    } slot_t;

    typedef struct {
        logic valid, rw, mr, mw, m2r, br, hz;
        logic [63:0] pc, imm, a, b, st;
        logic [4:0]  rd;
        logic [3:0]  alu;
    } exp_t;

    slot_t  model;
    slot_t  empty_slot;
    stim_t  cur;
    exp_t   sb_q[$];
    int     vectors = 0;
    int     miscompares = 0;

    function automatic logic [63:0] forward(stim_t s, logic [4:0] rs, logic [63:0] held);
        if (rs == 5'd0) return held;
        if (s.exmem_rw && s.exmem_rd == rs) return s.exmem_res;
        if (s.memwb_rw && s.memwb_rd == rs) return s.memwb_data;
        return held;
    endfunction

    function automatic bit hazard(slot_t m, stim_t s);
        return m.valid && m.mr && m.rd != 5'd0 && s.id_valid && (m.rd == s.rs1 || m.rd == s.rs2);
    endfunction

    function automatic exp_t predict(slot_t m, stim_t s);
        exp_t e;
        e.valid = m.valid;
        e.pc    = m.pc;
        e.imm   = m.imm;
        e.rd    = m.rd;
        e.alu   = m.alu;
        e.a     = forward(s, m.rs1, m.rs1d);
        e.st    = forward(s, m.rs2, m.rs2d);
        e.b     = m.alu_src ? m.imm : e.st;
        e.rw    = m.valid && m.rw;
        e.mr    = m.valid && m.mr;
        e.mw    = m.valid && m.mw;
        e.br    = m.valid && m.br;
        e.m2r   = m.m2r;
        e.hz    = hazard(m, s);
        return e;
    endfunction

    function automatic slot_t advance(slot_t m, stim_t s);
        slot_t n;
        if (s.reset || s.flush) return empty_slot;
        if (s.stall) return m;
        if (hazard(m, s)) return empty_slot;
        n.valid = s.id_valid; n.pc = s.pc; n.rs1d = s.rs1d; n.rs2d = s.rs2d; n.imm = s.imm;
        n.rs1 = s.rs1; n.rs2 = s.rs2; n.rd = s.rd; n.alu = s.alu; n.alu_src = s.alu_src;
        n.rw = s.rw; n.mr = s.mr; n.mw = s.mw; n.m2r = s.m2r; n.br = s.br;
        return n;
    endfunction

    function automatic stim_t zero_stim();
        stim_t s;
        s.reset = 0; s.stall = 0; s.flush = 0; s.id_valid = 0;
        s.pc = 0; s.rs1d = 0; s.rs2d = 0; s.imm = 0; s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.alu = 0;
        s.alu_src = 0; s.rw = 0; s.mr = 0; s.mw = 0; s.m2r = 0; s.br = 0;
        s.exmem_rd = 0; s.memwb_rd = 0; s.exmem_rw = 0; s.memwb_rw = 0;
        s.exmem_res = 0; s.memwb_data = 0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.reset = ($urandom_range(0, 39) == 0);
        s.flush = ($urandom_range(0, 9) == 0);
        s.stall = ($urandom_range(0, 5) == 0);
        s.id_valid = ($urandom_range(0, 3) != 0);
        s.pc = {$urandom, $urandom}; s.rs1d = {$urandom, $urandom};
        s.rs2d = {$urandom, $urandom}; s.imm = {$urandom, $urandom};
        s.rs1 = 5'($urandom_range(0, 7)); s.rs2 = 5'($urandom_range(0, 7));
        s.rd = 5'($urandom_range(0, 7)); s.alu = 4'($urandom);
        s.alu_src = 1'($urandom); s.rw = 1'($urandom); s.mr = ($urandom_range(0, 2) == 0);
        s.mw = 1'($urandom); s.m2r = 1'($urandom); s.br = 1'($urandom);
        s.exmem_rd = 5'($urandom_range(0, 7)); s.memwb_rd = 5'($urandom_range(0, 7));
        s.exmem_rw = 1'($urandom); s.memwb_rw = 1'($urandom);
        s.exmem_res = {$urandom, $urandom}; s.memwb_data = {$urandom, $urandom};
        return s;
    endfunction

    task automatic begin_cycle(input stim_t s);
        cur = s;
        reset = s.reset; stall = s.stall; flush = s.flush; id_valid = s.id_valid;
        id_pc = s.pc; id_rs1_data = s.rs1d; id_rs2_data = s.rs2d; id_imm = s.imm;
        id_rs1_addr = s.rs1; id_rs2_addr = s.rs2; id_rd_addr = s.rd; id_alu_control = s.alu;
        id_alu_src = s.alu_src; id_reg_write = s.rw; id_mem_read = s.mr;
        id_mem_write = s.mw; id_mem_to_reg = s.m2r; id_branch = s.br;
        exmem_rd = s.exmem_rd; exmem_reg_write = s.exmem_rw; exmem_alu_result = s.exmem_res;
        memwb_rd = s.memwb_rd; memwb_reg_write = s.memwb_rw; memwb_write_data = s.memwb_data;
        sb_q.push_back(predict(model, s));
    endtask

    task automatic end_cycle();
        @(posedge clk);
        model = advance(model, cur);
        #1;
    endtask

    task automatic drive(input stim_t s);
        begin_cycle(s);
        end_cycle();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares every presented EX output set against the queue.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            bit   bad;
            e = sb_q.pop_front();
            bad = 0;
            if (ex_valid        !== e.valid) bad = 1;
            if (ex_pc           !== e.pc)    bad = 1;
            if (ex_imm          !== e.imm)   bad = 1;
            if (ex_rd_addr      !== e.rd)    bad = 1;
            if (ex_alu_control  !== e.alu)   bad = 1;
            if (ex_alu_a        !== e.a)     bad = 1;
            if (ex_alu_b        !== e.b)     bad = 1;
            if (ex_store_data   !== e.st)    bad = 1;
            if (ex_reg_write    !== e.rw)    bad = 1;
            if (ex_mem_read     !== e.mr)    bad = 1;
            if (ex_mem_write    !== e.mw)    bad = 1;
            if (ex_mem_to_reg   !== e.m2r)   bad = 1;
            if (ex_branch       !== e.br)    bad = 1;
            if (load_use_hazard !== e.hz)    bad = 1;
            vectors++;
            if (bad) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t: got v=%b pc=%h rd=%0d alu=%h a=%h b=%h st=%h ctl=%b%b%b%b%b hz=%b, expected v=%b pc=%h rd=%0d alu=%h a=%h b=%h st=%h ctl=%b%b%b%b%b hz=%b",
                         $time, ex_valid, ex_pc, ex_rd_addr, ex_alu_control, ex_alu_a, ex_alu_b,
                         ex_store_data, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                         ex_branch, load_use_hazard, e.valid, e.pc, e.rd, e.alu, e.a, e.b, e.st,
                         e.rw, e.mr, e.mw, e.m2r, e.br, e.hz);
            end
        end
    end

    initial begin
        stim_t s;
        empty_slot = '{valid: 0, pc: 0, rs1d: 0, rs2d: 0, imm: 0, rs1: 0, rs2: 0, rd: 0,
                       alu: 0, alu_src: 0, rw: 0, mr: 0, mw: 0, m2r: 0, br: 0};
        model = empty_slot;
        s = zero_stim();
        s.reset = 1;
        cur = s;
        reset = 1; stall = 0; flush = 0; id_valid = 0;
        id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_alu_control = 0;
        id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        id_mem_to_reg = 0; id_branch = 0;
        exmem_rd = 0; exmem_reg_write = 0; exmem_alu_result = 0;
        memwb_rd = 0; memwb_reg_write = 0; memwb_write_data = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        begin_cycle(zero_stim());
        #1;
        check("reset_valid", {63'd0, ex_valid}, 64'd0);
        check("reset_pc", ex_pc, 64'd0);
        check("reset_alu_a", ex_alu_a, 64'd0);
        end_cycle();

        // Plain ADD load, one-cycle latency
        s = zero_stim();
        s.id_valid = 1; s.alu = 4'b0010; s.rs1d = 64'd5; s.rs2d = 64'd7;
        s.rs1 = 5'd1; s.rs2 = 5'd2; s.rd = 5'd4; s.pc = 64'h100;
        drive(s);
        begin_cycle(zero_stim());
        #1;
        check("load_alu_a", ex_alu_a, 64'd5);
        check("load_alu_b", ex_alu_b, 64'd7);
        check("load_alu_ctl", {60'd0, ex_alu_control}, 64'd2);
        check("load_valid", {63'd0, ex_valid}, 64'd1);
        end_cycle();

        // Forward priority on rs1 = x3
        s = zero_stim();
        s.id_valid = 1; s.rs1 = 5'd3; s.rs1d = 64'h11; s.alu = 4'b0010;
        drive(s);
        s = zero_stim();
        s.stall = 1; s.exmem_rd = 5'd3; s.exmem_rw = 1; s.exmem_res = 64'hAA;
        s.memwb_rd = 5'd3; s.memwb_rw = 1; s.memwb_data = 64'hBB;
        begin_cycle(s);
        #1;
        check("fwd_exmem_wins", ex_alu_a, 64'hAA);
        end_cycle();
        s.exmem_rw = 0;
        begin_cycle(s);
        #1;
        check("fwd_memwb", ex_alu_a, 64'hBB);
        end_cycle();

        // x0 is never forwarded
        s = zero_stim();
        s.id_valid = 1; s.rs1 = 5'd0; s.rs1d = 64'd0;
        drive(s);
        s = zero_stim();
        s.stall = 1; s.exmem_rd = 5'd0; s.exmem_rw = 1; s.exmem_res = 64'hFF;
        begin_cycle(s);
        #1;
        check("x0_no_fwd", ex_alu_a, 64'd0);
        end_cycle();

        // Load-use bubble
        s = zero_stim();
        s.id_valid = 1; s.mr = 1; s.rw = 1; s.m2r = 1; s.rd = 5'd5; s.rs1 = 5'd1;
        drive(s);
        s = zero_stim();
        s.id_valid = 1; s.rs1 = 5'd6; s.rs2 = 5'd5; s.rd = 5'd7;
        begin_cycle(s);
        #1;
        check("lu_hazard_high", {63'd0, load_use_hazard}, 64'd1);
        end_cycle();
        begin_cycle(s);
        #1;
        check("lu_bubble_valid", {63'd0, ex_valid}, 64'd0);
        check("lu_bubble_mem_read", {63'd0, ex_mem_read}, 64'd0);
        check("lu_hazard_drop", {63'd0, load_use_hazard}, 64'd0);
        end_cycle();

        // Stall holds for three cycles, then stall+flush bubbles
        s = zero_stim();
        s.id_valid = 1; s.pc = 64'h2468; s.rd = 5'd9; s.rw = 1;
        drive(s);
        for (int i = 0; i < 3; i++) begin
            s = rand_stim();
            s.reset = 0; s.flush = 0; s.stall = 1;
            begin_cycle(s);
            #1;
            check("stall_hold_pc", ex_pc, 64'h2468);
            check("stall_hold_valid", {63'd0, ex_valid}, 64'd1);
            end_cycle();
        end
        s = zero_stim();
        s.stall = 1; s.flush = 1; s.id_valid = 1;
        drive(s);
        begin_cycle(zero_stim());
        #1;
        check("stall_flush_valid", {63'd0, ex_valid}, 64'd0);
        end_cycle();

        // Reset mid-stream overrides stall
        s = zero_stim();
        s.id_valid = 1; s.pc = 64'h77; s.rw = 1; s.mr = 1; s.rd = 5'd3;
        drive(s);
        s = zero_stim();
        s.stall = 1; s.reset = 1;
        drive(s);
        s = zero_stim();
        s.id_valid = 1; s.rs1 = 5'd3;
        begin_cycle(s);
        #1;
        check("rst_valid", {63'd0, ex_valid}, 64'd0);
        check("rst_pc", ex_pc, 64'd0);
        check("rst_reg_write", {63'd0, ex_reg_write}, 64'd0);
        check("rst_hazard", {63'd0, load_use_hazard}, 64'd0);
        end_cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) drive(rand_stim());

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
